// File: rtl/core_fetch.sv
// Instruction fetch front end: credit-limited halfword requests, in-order prefetch FIFO, flush squashing.
// Optional FETCH_BYPASS_EN: a response arriving while the FIFO is empty and decode is ready goes straight to insn.
module core_fetch #(
  parameter int                ADDR_W   = 31,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ready,
  input  logic              fetch_rvalid,
  input  logic [15:0]       fetch_rdata,
  output logic [15:0]       insn,
  output logic [ADDR_W-1:0] insn_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     outst_q, outst_d, squash_q, squash_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic              boot_q;

  logic [15:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

  logic [CW-1:0] occ;
  logic [CW:0]   in_use;
  logic          empty, rsp_live, rsp_drop, bypass_take, push, pop, accept;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign empty    = (occ == '0);
  assign in_use   = {1'b0, occ} + {1'b0, outst_q};
  assign rsp_live = fetch_rvalid && (squash_q == '0);
  assign rsp_drop = fetch_rvalid && (squash_q != '0);

  // boot_q holds off the first request for one cycle after reset
  assign fetch_valid = !flush && !boot_q && (in_use < DEPTH_C);
  assign fetch_addr  = fetch_pc_q;
  assign accept      = fetch_valid && fetch_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass_take = empty && !stall && !flush && rsp_live;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = rsp_live && !flush && !bypass_take;
  assign pop  = !stall && !flush && !empty;

  always_comb begin
    insn    = 16'h0000;
    insn_pc = '0;
    if (bypass_take) begin
      insn    = fetch_rdata;
      insn_pc = rsp_pc_q;
    end else if (!empty) begin
      insn    = fifo_data_q[rd_ptr_q[PW-1:0]];
      insn_pc = fifo_pc_q[rd_ptr_q[PW-1:0]];
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q + ADDR_W'(accept);
    rsp_pc_d   = rsp_pc_q + ADDR_W'(rsp_live);
    outst_d    = outst_q + CW'(accept) - CW'(rsp_live);
    squash_d   = squash_q - CW'(rsp_drop);
    wr_ptr_d   = wr_ptr_q + CW'(push);
    rd_ptr_d   = rd_ptr_q + CW'(pop);
    if (flush) begin
      // whatever response lands this cycle is one of the in-flight ones and is dropped here
      fetch_pc_d = flush_target;
      rsp_pc_d   = flush_target;
      squash_d   = squash_q + outst_q - CW'(fetch_rvalid);
      outst_d    = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      squash_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      boot_q     <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      squash_q   <= squash_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      boot_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data_q[wr_ptr_q[PW-1:0]] <= fetch_rdata;
      fifo_pc_q[wr_ptr_q[PW-1:0]]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// Scoreboard bench for core_fetch: stimulus queues expected {pc, insn}; a negedge monitor pops on each consumed insn.
module tb_core_fetch;
  localparam int ADDR_W = 31;
  localparam int DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
  localparam int BYP_LAT = 0;
`else
  localparam int BYP_LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [ADDR_W-1:0] flush_target = '0;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready = 1'b1, fetch_rvalid = 1'b0;
  logic [15:0]       fetch_rdata = 16'h0;
  logic [15:0]       insn;
  logic [ADDR_W-1:0] insn_pc;

  logic              w_fetch_valid;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [15:0]       w_insn;
  logic [ADDR_W-1:0] w_insn_pc;

  core_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_target(flush_target),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .insn(insn), .insn_pc(insn_pc));

  // second instance only exercises the fetch address wrap from a high reset PC
  core_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(31'h7FFF_FFFE)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b1), .flush(1'b0), .flush_target(31'h0),
    .fetch_valid(w_fetch_valid), .fetch_addr(w_fetch_addr), .fetch_ready(1'b1),
    .fetch_rvalid(1'b0), .fetch_rdata(16'h0), .insn(w_insn), .insn_pc(w_insn_pc));

  typedef struct { logic [ADDR_W-1:0] pc; logic [15:0] data; } exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } req_t;

  exp_t exp_q[$];
  req_t pend[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, last_due = 0, mon_due;
  int   lat_min = 1, lat_max = 1;
  bit   rdy_rand = 1'b0, stall_rand = 1'b0;
  int   inflight = 0, n_got = 0, n_acc = 0;

  function automatic logic [15:0] memf(input logic [ADDR_W-1:0] a);
    return a[15:0] + 16'h0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory: in-order responses, one per cycle, no earlier than their due cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      fetch_rvalid = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      fetch_rvalid = 1'b1;
      fetch_rdata  = memf(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      fetch_rvalid = 1'b0;
      fetch_rdata  = 16'hDEAD;
    end
    fetch_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: request capture, consumption scoreboard, credit bound
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      inflight = 0;
      last_due = 0;
    end else begin
      if (flush) inflight = 0;
      if (fetch_valid && fetch_ready) begin
        mon_due = cyc + $urandom_range(lat_min, lat_max);
        if (mon_due <= last_due) mon_due = last_due + 1;
        last_due = mon_due;
        pend.push_back('{fetch_addr, mon_due});
        inflight++;
        n_acc++;
      end
      if (!flush && !stall && insn !== 16'h0000) begin
        inflight--;
        n_got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_insn: got pc %h insn %h expected none", insn_pc, insn);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("insn_pc", 32'(insn_pc), 32'(e.pc));
          chk("insn", 32'(insn), 32'(e.data));
        end
      end
      if (inflight > DEPTH) begin
        n_cmp++; n_bad++;
        $display("FAIL credit: in use %0d expected <= %0d", inflight, DEPTH);
      end
      if (int'(dut.squash_q) > DEPTH) begin
        n_cmp++; n_bad++;
        $display("FAIL squash_sat: got %0d expected <= %0d", dut.squash_q, DEPTH);
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] p;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      p = start + ADDR_W'(i);
      exp_q.push_back('{p, memf(p)});
    end
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] start, input int n, input logic st);
    @(posedge clk); #2;
    rst = 1'b1; stall = st; flush = 1'b0;
    push_exp(start, n);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0; n_got = 0; n_acc = 0;
  endtask

  task automatic do_flush(input logic [ADDR_W-1:0] t, input int n);
    @(posedge clk); #2;
    flush = 1'b1; flush_target = t;
    push_exp(t, n);
    n_got = 0;
    @(posedge clk); #2;
    flush = 1'b0;
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    for (int i = 0; i < budget && n_got < n; i++) begin
      @(posedge clk); #2;
      if (stall_rand) stall = ($urandom_range(0, 3) == 0);
    end
    chk(name, 32'(n_got >= n), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rv, ins, k;
    logic [ADDR_W-1:0] w_exp [4];
    w_exp[0] = 31'h7FFF_FFFE; w_exp[1] = 31'h7FFF_FFFF; w_exp[2] = 31'h0; w_exp[3] = 31'h1;

    // A: reset state, streaming, first-response latency, wrap on the high-PC instance
    do_reset('0, 64, 1'b0);
    @(negedge clk); #1;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_insn", 32'(insn), 32'd0);
    chk("rst_insn_pc", 32'(insn_pc), 32'd0);
    chk("w_rst_valid", 32'(w_fetch_valid), 32'd0);
    chk("w_rst_addr", 32'(w_fetch_addr), 32'h7FFF_FFFE);
    rv = -1; ins = -1;
    for (k = 1; k < 20; k++) begin
      @(negedge clk); #1;
      if (k <= 4) begin
        chk("w_valid", 32'(w_fetch_valid), 32'd1);
        chk("w_addr", 32'(w_fetch_addr), 32'(w_exp[k-1]));
      end else if (k == 5) begin
        chk("w_credit_stop", 32'(w_fetch_valid), 32'd0);
      end
      if (fetch_rvalid && rv < 0) rv = k;
      if (insn != 16'h0 && ins < 0) ins = k;
    end
    chk("first_rsp_seen", 32'(rv >= 0), 32'd1);
    chk("rsp_to_insn_latency", 32'(ins - rv), 32'(BYP_LAT));
    wait_got("A_stream", 30, 300);

    // B: stall holds PC 0 and credits fill
    do_reset('0, 64, 1'b1);
    k = 0;
    while (insn == 16'h0 && k < 50) begin @(negedge clk); #1; k++; end
    chk("B_first_valid", 32'(insn != 16'h0), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("B_hold_pc", 32'(insn_pc), 32'd0);
    chk("B_hold_insn", 32'(insn), 32'h0100);
    chk("B_credit_full", 32'(fetch_valid), 32'd0);
    chk("B_in_use", 32'(inflight), 32'(DEPTH));
    @(posedge clk); #2;
    stall = 1'b0;
    wait_got("B_resume", 20, 300);

    // C: flush with three requests in flight at latency 4
    lat_min = 4; lat_max = 4;
    do_reset('0, 64, 1'b0);
    k = 0;
    while (n_acc < 3 && k < 50) begin @(negedge clk); #1; k++; end
    chk("C_three_out", 32'(n_acc), 32'd3);
    do_flush(31'h40, 64);
    @(negedge clk); #1;
    chk("C_after_flush_insn", 32'(insn), 32'd0);
    wait_got("C_redirect", 10, 300);

    // D: flush and stall together with the FIFO full
    lat_min = 1; lat_max = 1;
    do_reset('0, 64, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    chk("D_full", 32'(inflight), 32'(DEPTH));
    chk("D_no_req", 32'(fetch_valid), 32'd0);
    @(posedge clk); #2;
    flush = 1'b1; flush_target = 31'h80;
    push_exp(31'h80, 64);
    n_got = 0;
    @(negedge clk); #1;
    chk("D_flush_cycle_valid", 32'(fetch_valid), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk); #1;
    chk("D_empty_insn", 32'(insn), 32'd0);
    chk("D_empty_pc", 32'(insn_pc), 32'd0);
    chk("D_addr", 32'(fetch_addr), 32'h80);
    chk("D_valid", 32'(fetch_valid), 32'd1);
    @(posedge clk); #2;
    stall = 1'b0;
    wait_got("D_resume", 10, 300);

    // F: random ready/stall, latency 1..3, flushes mid-stream including a PC wrap
    lat_min = 1; lat_max = 3; rdy_rand = 1'b1; stall_rand = 1'b1;
    do_reset('0, 300, 1'b0);
    wait_got("F_seg0", 250, 3000);
    do_flush(31'h1000, 300);
    wait_got("F_seg1", 250, 3000);
    do_flush(31'h2000, 300);
    wait_got("F_seg2", 250, 3000);
    do_flush(31'h7FFF_FFFE, 300);
    wait_got("F_seg3_wrap", 250, 3000);
    stall_rand = 1'b0; stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Front-end stage directly upstream of the decode stage.
- Issues halfword instruction fetches to the instruction memory port and buffers the returned instructions in an in-order prefetch FIFO.
- Presents one instruction and its PC per cycle to decode.
- Honours decode's stall and redirects on flush to a supplied branch target, squashing all in-flight responses.

Parameters:
- ADDR_W, 31: width of halfword instruction pointer (insn_pc, fetch_addr, flush_target).
- DEPTH, 4: prefetch FIFO entries; also the maximum outstanding requests plus buffered entries. Must be a power of two, ≥2.
- RESET_PC, 0: halfword address fetched first after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  decode not accepting; hold current output instruction.
- flush  in  1  redirect; discard buffered and in-flight instructions.
- flush_target  in  ADDR_W  new fetch PC, valid when flush=1.
- fetch_valid  out  1  request valid.
- fetch_addr  out  ADDR_W  halfword address of request.
- fetch_ready  in  1  memory accepts request this cycle.
- fetch_rvalid  in  1  response valid. Responses are in request order, at least 1 cycle after acceptance.
- fetch_rdata  in  16  returned instruction halfword.
- insn  out  16  instruction to decode; 16'h0000 (NOP) when none available.
- insn_pc  out  ADDR_W  PC of insn; 0 when none available.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetch PC ← RESET_PC.
  - FIFO empty; outstanding=0; squash=0.
  - fetch_valid=0 in the cycle after reset.
  - insn=0, insn_pc=0.
- Credit rule:
  - fetch_valid = !flush && (occupancy + outstanding < DEPTH).
  - fetch_addr = fetch PC.
- Request acceptance: on fetch_valid && fetch_ready, fetch PC += 1 (modulo 2^ADDR_W; wraps from all-ones to 0) and outstanding += 1.
- Response handling, on fetch_rvalid:
  - If squash > 0: squash −= 1, data dropped.
  - Otherwise: push {fetch_rdata, response PC} into FIFO and outstanding −= 1.
  - Response PC is tracked by a separate response-PC counter advanced per non-squashed response.
- Output:
  - insn/insn_pc are the FIFO head, combinational from FIFO state.
  - Pop when !stall && !flush && FIFO non-empty.
  - Empty FIFO → insn=0, insn_pc=0. Decode treats this as NOP.
- Flush (highest priority over stall, pop, push):
  - Next cycle: FIFO empty.
  - fetch PC ← flush_target; response-PC counter ← flush_target.
  - squash ← squash + outstanding, minus 1 if a response arrives in the flush cycle; that response is dropped.
  - outstanding ← 0.
  - A request accepted in the flush cycle cannot occur (fetch_valid=0).
- Simultaneous push and pop on a full FIFO: legal; occupancy is unchanged. Credit rule makes push on full-without-pop impossible; the bench must flag it as an error.
- Stall with empty FIFO: output stays NOP; fetching continues up to the credit limit.
- Counters:
  - occupancy, outstanding, and squash are each clog2(DEPTH)+1 bits.
  - squash saturates at DEPTH (cannot exceed it by construction); the bench asserts it.
- Reset mid-operation: all state cleared per the reset rule. Responses arriving later for pre-reset requests are not squashed; the memory must also be reset.

Optional Feature:
- FETCH_BYPASS_EN
- Defined: when FIFO is empty, !stall, !flush, and a non-squashed response arrives, insn/insn_pc show that response combinationally in the same cycle. It is consumed without entering the FIFO; 0-cycle buffering latency.
- Undefined: every response is written into the FIFO and appears on insn one cycle later. Minimum request-to-decode latency is 1 cycle higher.

Test Plan:
- Reset, fetch_ready=1, memory returns mem[a]=a+16'h100 with 1-cycle latency, no stall → insn_pc sequence 0,1,2,3… with insn 0x0100,0x0101,…; never more than 4 outstanding+buffered.
- Hold stall=1 for 10 cycles after first valid insn (PC 0) → insn_pc stays 0; fetch_valid drops after occupancy+outstanding=4; releasing stall resumes PCs 1,2,3 in order with no gaps or duplicates.
- With 3 requests outstanding (latency 4), assert flush with flush_target=0x40 → next 3 responses dropped; first insn after flush has insn_pc=0x40, insn=mem[0x40].
- flush and stall asserted together at occupancy 4 → FIFO empties next cycle, fetch_addr=flush_target, insn=0.
- RESET_PC=2^31−2 → fetch_addr sequence 0x7FFFFFFE,0x7FFFFFFF,0 and insn_pc wraps identically.
- fetch_ready toggles randomly with latency 1–3; compare insn stream against golden PC model for 1000 instructions. With FETCH_BYPASS_EN, the first instruction after reset appears the same cycle its response arrives.
